// File: rtl/if_id_buf.sv
// Fetch-to-decode pipeline buffer: a 2-entry skid buffer with a registered if_ready,
// a synchronous redirect flush and a delivered-instruction counter.
module if_id_buf #(
  parameter int                 INST_W   = 32,
  parameter int                 PC_W     = 64,
  parameter logic [INST_W-1:0]  NOP_INST = 'h0000_0013,
  parameter int                 CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [INST_W-1:0] if_inst,
  input  logic [PC_W-1:0]   if_pc,
  input  logic              pipeline_flush,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [CNT_W-1:0]  inst_cnt
);

  // EMPTY: nothing held; BUSY: main only; FULL: main and skid.
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t              state_q, state_d;
  logic [INST_W-1:0]   main_inst_q, main_inst_d;
  logic [PC_W-1:0]     main_pc_q, main_pc_d;
  logic [INST_W-1:0]   skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]     skid_pc_q, skid_pc_d;
  logic                if_ready_q, if_ready_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                main_valid;
  logic                in_fire;
  logic                out_fire;

  assign main_valid = (state_q != EMPTY);
  assign in_fire    = if_valid & if_ready_q;
  assign out_fire   = main_valid & id_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      main_inst_q <= NOP_INST;
      main_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      if_ready_q  <= 1'b1;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      if_ready_q  <= if_ready_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    // A delivery in the flush cycle still happened from IDU's point of view.
    cnt_d       = cnt_q + CNT_W'(out_fire);

    if (pipeline_flush) begin
      state_d     = EMPTY;
      main_inst_d = NOP_INST;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            main_inst_d = if_inst;
            main_pc_d   = if_pc;
            state_d     = BUSY;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_inst_d = if_inst;
            main_pc_d   = if_pc;
          end else if (in_fire) begin
            skid_inst_d = if_inst;
            skid_pc_d   = if_pc;
            state_d     = FULL;
          end else if (out_fire) begin
            main_inst_d = NOP_INST;
            state_d     = EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_inst_d = skid_inst_q;
            main_pc_d   = skid_pc_q;
            state_d     = BUSY;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_inst_d = NOP_INST;
        end
      endcase
    end

    // Registered ready tracks "skid will be free", so no id_ready->if_ready path exists.
    if_ready_d = (state_d != FULL);
  end

  assign if_ready = if_ready_q;
  assign id_valid = main_valid;
  assign id_inst  = main_inst_q;
  assign id_pc    = main_pc_q;
  assign inst_cnt = cnt_q;

endmodule

// File: tb/tb_if_id_buf.sv
// Directed bench for if_id_buf: a queue scoreboard models occupancy, order and count;
// a second instance with a 4-bit counter covers wrap-around.
module tb_if_id_buf;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [63:0] if_pc;
  logic        pipeline_flush;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [63:0] id_pc;
  logic [63:0] inst_cnt;

  logic        if_ready4;
  logic        id_valid4;
  logic [31:0] id_inst4;
  logic [63:0] id_pc4;
  logic [3:0]  inst_cnt4;

  int checks   = 0;
  int failures = 0;

  logic [31:0] q_inst[$];
  logic [63:0] q_pc[$];
  logic [63:0] cnt_m;
  logic [63:0] next_pc;
  logic [31:0] next_inst;
  logic        accepted;
  logic [63:0] cnt_before;

  if_id_buf dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .pipeline_flush(pipeline_flush),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
    .id_pc(id_pc), .inst_cnt(inst_cnt)
  );

  if_id_buf #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready4),
    .if_inst(if_inst), .if_pc(if_pc), .pipeline_flush(pipeline_flush),
    .id_valid(id_valid4), .id_ready(id_ready), .id_inst(id_inst4),
    .id_pc(id_pc4), .inst_cnt(inst_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check outputs of the current cycle, advance the model, clock once, check the count.
  task automatic step();
    logic in_f;
    logic out_f;
    chk("id_valid", 64'(id_valid), 64'(q_pc.size() != 0));
    chk("if_ready", 64'(if_ready), 64'(q_pc.size() < 2));
    chk("if_ready4", 64'(if_ready4), 64'(q_pc.size() < 2));
    chk("id_valid4", 64'(id_valid4), 64'(q_pc.size() != 0));
    if (q_pc.size() != 0) begin
      chk("id_pc", id_pc, q_pc[0]);
      chk("id_inst", 64'(id_inst), 64'(q_inst[0]));
      chk("id_pc4", id_pc4, q_pc[0]);
    end else begin
      chk("id_inst_nop", 64'(id_inst), 64'(NOP));
    end
    in_f  = if_valid && (q_pc.size() < 2);
    out_f = (q_pc.size() != 0) && id_ready;
    if (out_f) begin
      void'(q_pc.pop_front());
      void'(q_inst.pop_front());
      cnt_m = cnt_m + 64'd1;
    end
    if (pipeline_flush) begin
      q_pc.delete();
      q_inst.delete();
    end else if (in_f) begin
      q_pc.push_back(if_pc);
      q_inst.push_back(if_inst);
    end
    accepted = in_f;
    @(posedge clk);
    @(negedge clk);
    chk("inst_cnt", inst_cnt, cnt_m);
    chk("inst_cnt4", 64'(inst_cnt4), 64'(cnt_m[3:0]));
    $display("step pc=%h in=%0b out=%0b flush=%0b occ=%0d cnt=%0d",
             if_pc, in_f, out_f, pipeline_flush, q_pc.size(), cnt_m);
  endtask

  task automatic offer_step();
    if_pc   = next_pc;
    if_inst = next_inst;
    step();
    if (accepted) begin
      next_pc   = next_pc + 64'd4;
      next_inst = $urandom;
    end
  endtask

  initial begin
    rst = 1'b0; if_valid = 1'b0; if_inst = '0; if_pc = '0;
    pipeline_flush = 1'b0; id_ready = 1'b0;
    cnt_m = '0; next_pc = 64'h8000_0000; next_inst = $urandom;

    #12;
    chk("rst_id_valid", 64'(id_valid), 64'd0);
    chk("rst_if_ready", 64'(if_ready), 64'd1);
    chk("rst_id_inst", 64'(id_inst), 64'(NOP));
    chk("rst_id_pc", id_pc, 64'd0);
    chk("rst_inst_cnt", inst_cnt, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Streaming 17 beats at full rate, then drain; small counter wraps to 1.
    id_ready = 1'b1; if_valid = 1'b1;
    for (int i = 0; i < 17; i++) offer_step();
    if_valid = 1'b0;
    step();
    chk("wrap_cnt4", 64'(inst_cnt4), 64'd1);
    chk("stream_cnt", inst_cnt, 64'd17);

    // Backpressure: three offers while stalled, then drain in order.
    next_pc = 64'h8000_0000;
    id_ready = 1'b0; if_valid = 1'b1;
    for (int i = 0; i < 3; i++) offer_step();
    chk("bp_if_ready", 64'(if_ready), 64'd0);
    chk("bp_hold_pc", id_pc, 64'h8000_0000);
    id_ready = 1'b1;
    offer_step();
    offer_step();
    if_valid = 1'b0;
    for (int i = 0; i < 3; i++) offer_step();

    // Flush while FULL.
    id_ready = 1'b0; if_valid = 1'b1;
    offer_step();
    offer_step();
    if_valid = 1'b0; pipeline_flush = 1'b1;
    offer_step();
    pipeline_flush = 1'b0;
    chk("fl_id_valid", 64'(id_valid), 64'd0);
    chk("fl_id_inst", 64'(id_inst), 64'(NOP));
    chk("fl_if_ready", 64'(if_ready), 64'd1);
    if_valid = 1'b1;
    offer_step();
    if_valid = 1'b0; id_ready = 1'b1;
    offer_step();
    offer_step();

    // Flush with simultaneous in_fire and out_fire.
    if_valid = 1'b1; id_ready = 1'b1;
    offer_step();
    cnt_before = cnt_m;
    pipeline_flush = 1'b1;
    offer_step();
    pipeline_flush = 1'b0;
    chk("flio_cnt", inst_cnt, cnt_before + 64'd1);
    chk("flio_empty", 64'(id_valid), 64'd0);
    if_valid = 1'b0;
    offer_step();

    // Asynchronous reset mid-FULL, checked before any clock edge.
    id_ready = 1'b0; if_valid = 1'b1;
    offer_step();
    offer_step();
    chk("pre_rst_full", 64'(if_ready), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_id_valid", 64'(id_valid), 64'd0);
    chk("arst_if_ready", 64'(if_ready), 64'd1);
    chk("arst_inst_cnt", inst_cnt, 64'd0);
    q_pc.delete(); q_inst.delete(); cnt_m = '0;
    @(negedge clk);
    rst = 1'b1; if_valid = 1'b0;
    offer_step();
    if_valid = 1'b1; id_ready = 1'b1;
    offer_step();
    if_valid = 1'b0;
    offer_step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
